// File: rtl/ps_bigreg_bridge_pkg.sv
// Shared types and per-register mem-map layout for the big-register bridges.
package ps_bigreg_bridge_pkg;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef logic [0:0] bigreg_state_t;
  localparam bigreg_state_t IDLE = 1'b0;
  localparam bigreg_state_t HOLD = 1'b1;

  localparam int CHANMUX_BASE_ID   = 30;
  localparam int CHANMUX_NUM_WORDS = 2;
  localparam int SEEDS_BASE_ID     = 64;
  localparam int SEEDS_NUM_WORDS   = 16;
  localparam int SDC_BASE_ID       = 96;
  localparam int SDC_NUM_WORDS     = 16;

  // The trailing "valid" entry sits immediately after the last data word.
  function automatic int valid_id(input int base_id, input int num_words);
    return base_id + num_words;
  endfunction

endpackage

// File: rtl/ps_bigreg_bridge_if.sv
// Mem-map write/response port plus the committed-value handshake of one big register.
interface ps_bigreg_bridge_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WORDS  = 2,
  parameter int ID_W       = 8
) ();
  import ps_bigreg_bridge_pkg::*;

  logic                            wr_en;
  logic [ID_W-1:0]                 wr_id;
  logic [DATA_WIDTH-1:0]           wr_data;
  logic                            resp_valid;
  resp_t                           resp;
  logic [NUM_WORDS*DATA_WIDTH-1:0] out_data;
  logic                            out_valid;
  logic                            out_ready;

  modport master (
    output wr_en, wr_id, wr_data, out_ready,
    input  resp_valid, resp, out_data, out_valid
  );

  modport slave (
    input  wr_en, wr_id, wr_data, out_ready,
    output resp_valid, resp, out_data, out_valid
  );

endinterface

// File: rtl/ps_bigreg_bridge_hold_timer.sv
// Enable/clear counter with a terminal-count pulse on its TERMINAL-th enabled cycle.
module ps_bigreg_bridge_hold_timer #(
  parameter int TERMINAL = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

  logic [CW-1:0] cnt_reg;

  // TERMINAL of zero disables the pulse; the counter then just free-runs harmlessly.
  assign tc = (TERMINAL > 0) && en && !clr && (cnt_reg == CW'(TERMINAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr || tc) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ps_bigreg_bridge.sv
// Assembles NUM_WORDS mem-map writes into a shadow, commits it on the trailing
// valid-index write and offers the wide value to a consumer over valid/ready.
module ps_bigreg_bridge
  import ps_bigreg_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_WORDS      = 2,
  parameter int BASE_ID        = 30,
  parameter int MEM_SIZE       = 256,
  parameter int ALLOW_PARTIAL  = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 soft_clr,
  ps_bigreg_bridge_if.slave    bus,
  output logic [NUM_WORDS-1:0] fresh,
  output logic                 timeout_err
);

  localparam int ID_W = $clog2(MEM_SIZE);

  logic [DATA_WIDTH-1:0]           shadow_reg [NUM_WORDS];
  logic [NUM_WORDS*DATA_WIDTH-1:0] shadow_flat;
  logic [NUM_WORDS*DATA_WIDTH-1:0] out_data_reg;
  logic [NUM_WORDS-1:0]            word_hit;
  logic [NUM_WORDS-1:0]            fresh_reg, fresh_next;
  bigreg_state_t                   state_reg, state_next;
  resp_t                           resp_reg, resp_next;
  logic                            resp_valid_reg;
  logic                            timeout_err_reg, timeout_err_next;
  logic                            valid_hit, in_range, in_hold;
  logic                            commit_ok, commit, handshake, tmo;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign word_hit[gi] = bus.wr_en && (bus.wr_id == ID_W'(BASE_ID + gi));
      assign shadow_flat[gi*DATA_WIDTH +: DATA_WIDTH] = shadow_reg[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_reg[gi] <= '0;
        end else if (soft_clr) begin
          shadow_reg[gi] <= '0;
        end else if (word_hit[gi]) begin
          shadow_reg[gi] <= bus.wr_data;
        end
      end
    end
  endgenerate

  assign valid_hit = bus.wr_en && (bus.wr_id == ID_W'(BASE_ID + NUM_WORDS));
  assign in_range  = (|word_hit) || valid_hit;
  assign in_hold   = (state_reg == HOLD);
  assign handshake = in_hold && bus.out_ready;
  assign commit_ok = (&fresh_reg) || ((ALLOW_PARTIAL != 0) && (|fresh_reg));
  // A valid write while HOLD is busy even if the consumer accepts this cycle.
  assign commit    = valid_hit && !in_hold && commit_ok && !soft_clr;

  ps_bigreg_bridge_hold_timer #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .clr (!in_hold || soft_clr),
    .en  (in_hold && !bus.out_ready),
    .tc  (tmo)
  );

  always_comb begin
    state_next       = state_reg;
    fresh_next       = fresh_reg;
    resp_next        = resp_reg;
    timeout_err_next = timeout_err_reg;
    if (soft_clr) begin
      state_next       = IDLE;
      fresh_next       = '0;
      timeout_err_next = 1'b0;
      if (in_range) resp_next = RESP_SLVERR;
    end else begin
      if (in_range) resp_next = (valid_hit && !commit) ? RESP_SLVERR : RESP_OKAY;
      if (commit) begin
        state_next = HOLD;
        fresh_next = '0;
      end else begin
        fresh_next = fresh_reg | word_hit;
      end
      if (handshake) begin
        state_next = IDLE;
      end else if (tmo) begin
        state_next       = IDLE;
        timeout_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      fresh_reg       <= '0;
      resp_reg        <= RESP_OKAY;
      resp_valid_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
      out_data_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      fresh_reg       <= fresh_next;
      resp_reg        <= resp_next;
      resp_valid_reg  <= in_range;
      timeout_err_reg <= timeout_err_next;
      if (commit) out_data_reg <= shadow_flat;
    end
  end

  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp       = resp_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.out_valid  = in_hold;
  assign fresh          = fresh_reg;
  assign timeout_err    = timeout_err_reg;

endmodule

// File: tb/tb_ps_bigreg_bridge.sv
// Drives a strict/timeout bridge and a partial/no-timeout bridge with the same
// stimulus and compares both against a word-level reference model.
module tb_ps_bigreg_bridge;
  import ps_bigreg_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        soft_clr = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_id = '0;
  logic [15:0] wr_data = '0;
  logic        out_ready = 1'b0;
  logic [1:0]  fresh0, fresh1;
  logic        terr0, terr1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  localparam int AP [2] = '{0, 1};
  localparam int TO [2] = '{8, 0};

  logic [15:0] m_shadow [2][2];
  logic [1:0]  m_fresh  [2];
  logic [31:0] m_out    [2];
  bit          m_ov     [2];
  int          m_cnt    [2];
  bit          m_terr   [2];
  bit          m_rv     [2];
  logic [1:0]  m_resp   [2];

  always #5 clk = ~clk;

  ps_bigreg_bridge_if #(.DATA_WIDTH(16), .NUM_WORDS(2), .ID_W(8)) bus0 ();
  ps_bigreg_bridge_if #(.DATA_WIDTH(16), .NUM_WORDS(2), .ID_W(8)) bus1 ();

  assign bus0.wr_en = wr_en;  assign bus0.wr_id = wr_id;
  assign bus0.wr_data = wr_data;  assign bus0.out_ready = out_ready;
  assign bus1.wr_en = wr_en;  assign bus1.wr_id = wr_id;
  assign bus1.wr_data = wr_data;  assign bus1.out_ready = out_ready;

  ps_bigreg_bridge #(
    .DATA_WIDTH(16), .NUM_WORDS(2), .BASE_ID(30), .MEM_SIZE(256),
    .ALLOW_PARTIAL(0), .TIMEOUT_CYCLES(8)
  ) dut0 (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .bus(bus0.slave),
    .fresh(fresh0), .timeout_err(terr0)
  );

  ps_bigreg_bridge #(
    .DATA_WIDTH(16), .NUM_WORDS(2), .BASE_ID(30), .MEM_SIZE(256),
    .ALLOW_PARTIAL(1), .TIMEOUT_CYCLES(0)
  ) dut1 (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .bus(bus1.slave),
    .fresh(fresh1), .timeout_err(terr1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_shadow[k][0] = '0; m_shadow[k][1] = '0;
      m_fresh[k] = '0; m_out[k] = '0; m_ov[k] = 0; m_cnt[k] = 0;
      m_terr[k] = 0; m_rv[k] = 0; m_resp[k] = RESP_OKAY;
    end
  endtask

  // One clock of the register's rules, evaluated on the values seen before the edge.
  task automatic model_step(input int k);
    int idx;
    bit word, vld, ok, tmo, commit;
    idx    = int'(wr_id) - 30;
    word   = wr_en && idx >= 0 && idx < 2;
    vld    = wr_en && idx == 2;
    m_rv[k] = word || vld;
    commit = 0;
    if (soft_clr) begin
      m_shadow[k][0] = '0; m_shadow[k][1] = '0;
      m_fresh[k] = '0; m_ov[k] = 0; m_terr[k] = 0; m_cnt[k] = 0;
      if (m_rv[k]) m_resp[k] = RESP_SLVERR;
    end else begin
      ok  = ($countones(m_fresh[k]) == 2) || (AP[k] != 0 && m_fresh[k] != 0);
      tmo = TO[k] > 0 && m_ov[k] && !out_ready && m_cnt[k] == TO[k] - 1;
      if (word) begin
        m_shadow[k][idx] = wr_data;
        m_fresh[k][idx]  = 1'b1;
        m_resp[k]        = RESP_OKAY;
      end
      if (vld) begin
        if (!m_ov[k] && ok) begin
          m_out[k]   = {m_shadow[k][1], m_shadow[k][0]};
          m_fresh[k] = '0;
          m_resp[k]  = RESP_OKAY;
          commit     = 1;
        end else begin
          m_resp[k] = RESP_SLVERR;
        end
      end
      if (m_ov[k]) begin
        if (out_ready) m_ov[k] = 0;
        else if (tmo) begin m_ov[k] = 0; m_terr[k] = 1; end
        else m_cnt[k]++;
      end
      if (commit) begin m_ov[k] = 1; m_cnt[k] = 0; end
    end
  endtask

  task automatic check_one(input int k, input logic rv, input logic [1:0] rs,
                           input logic [1:0] fr, input logic ov, input logic [31:0] od,
                           input logic te);
    string p;
    p = (k == 0) ? "d0" : "d1";
    check({p, "_resp_valid"}, rv, m_rv[k]);
    if (m_rv[k]) check({p, "_resp"}, rs, m_resp[k]);
    check({p, "_fresh"}, fr, m_fresh[k]);
    check({p, "_out_valid"}, ov, m_ov[k]);
    check({p, "_out_data"}, od, m_out[k]);
    check({p, "_timeout_err"}, te, m_terr[k]);
  endtask

  task automatic check_all();
    check_one(0, bus0.resp_valid, bus0.resp, fresh0, bus0.out_valid, bus0.out_data, terr0);
    check_one(1, bus1.resp_valid, bus1.resp, fresh1, bus1.out_valid, bus1.out_data, terr1);
  endtask

  task automatic cycle(input bit en, input int id, input logic [15:0] data,
                       input bit clr, input bit rdy);
    wr_en = en; wr_id = 8'(id); wr_data = data; soft_clr = clr; out_ready = rdy;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    if (en)
      $display("txn cyc=%0d id=%0d data=%h clr=%0d rdy=%0d | d0 rv=%0d resp=%0d ov=%0d | d1 rv=%0d resp=%0d ov=%0d",
               cyc, id, data, clr, rdy, bus0.resp_valid, bus0.resp, bus0.out_valid,
               bus1.resp_valid, bus1.resp, bus1.out_valid);
  endtask

  task automatic wr(input int id, input logic [15:0] data, input bit rdy = 0);
    cycle(1, id, data, 0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, rdy);
  endtask

  initial begin
    int hi;
    model_reset();
    #13;
    check_all();
    check("reset_out_data", bus0.out_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full assembly and commit
    wr(30, 16'hBEEF); wr(31, 16'h1234); wr(32, 16'h0000);
    check("commit_full_data", bus0.out_data, 32'h1234_BEEF);
    check("commit_full_valid", bus0.out_valid, 1'b1);
    check("commit_full_fresh", fresh0, 2'b00);
    idle(1, 1); idle(1, 0);

    // Partial commit: strict instance refuses, partial instance merges
    wr(30, 16'h0001); wr(32, 16'h0000);
    check("strict_partial_resp", bus0.resp, RESP_SLVERR);
    check("strict_partial_fresh", fresh0, 2'b01);
    check("partial_data", bus1.out_data, 32'h1234_0001);
    idle(1, 1);
    wr(31, 16'h5678); wr(32, 16'h0000);
    check("strict_late_commit", bus0.out_data, 32'h5678_0001);

    // Busy: valid write during HOLD with consumer stalled
    wr(30, 16'hAAAA); wr(31, 16'hBBBB); wr(32, 16'h0000);
    check("busy_resp", bus0.resp, RESP_SLVERR);
    check("busy_fresh", fresh0, 2'b11);
    idle(1, 1);
    wr(32, 16'h0000);
    check("busy_retry_data", bus0.out_data, 32'hBBBB_AAAA);
    idle(1, 1);

    // Timeout: count observed HOLD samples
    wr(30, 16'h1111); wr(31, 16'h2222); wr(32, 16'h0000);
    hi = bus0.out_valid ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      idle(1, 0);
      if (bus0.out_valid) hi++;
    end
    check("timeout_hold_cycles", 64'(hi), 64'd8);
    check("timeout_err_set", terr0, 1'b1);
    cycle(0, 0, '0, 1, 1);
    check("soft_clr_terr", terr0, 1'b0);

    // Handshake on the terminal cycle wins over the timeout
    wr(30, 16'h3333); wr(31, 16'h4444); wr(32, 16'h0000);
    idle(7, 0); idle(1, 1);
    check("tmo_vs_hs_terr", terr0, 1'b0);

    // soft_clr coincident with a word write
    wr(30, 16'h9999);
    cycle(1, 31, 16'h7777, 1, 0);
    check("clr_write_resp", bus0.resp, RESP_SLVERR);
    check("clr_write_fresh", fresh0, 2'b00);

    // Neighbouring indices are ignored
    wr(29, 16'hDEAD);
    check("id29_no_resp", bus0.resp_valid, 1'b0);
    wr(33, 16'hDEAD);
    check("id33_no_resp", bus0.resp_valid, 1'b0);

    // Asynchronous reset while holding
    wr(30, 16'h0102); wr(31, 16'h0304); wr(32, 16'h0000);
    check("pre_rst_hold", bus0.out_valid, 1'b1);
    wr_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomised traffic around the register's index window
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 28 + int'($urandom_range(0, 6)),
            16'($urandom), $urandom_range(0, 60) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/ps_bigreg_bridge.md
Name: ps_bigreg_bridge

Overview:
- Generalised assembler for PS_BIGREG-style mem-map registers: collects NUM_WORDS consecutive WD_DATA_WIDTH writes from the AXI mem-map write port into a shadow register.
- Commits the shadow to a wide output register on a write to the trailing valid address, then presents it to RTL consumers over a valid/ready handshake.
- Adds per-word fresh tracking, optional partial commit, busy/incomplete error responses and a handshake timeout.
- One instance per big register (seeds, chan mux, SDC), sitting between the AXI slave decode and the consumer.

Parameters:
- DATA_WIDTH, 16, width of one mem-map entry.
- NUM_WORDS, 2, entries per big register (16 for seeds/SDC, 2 for chan mux).
- BASE_ID, 30, mem-map index of word 0; the valid index is BASE_ID+NUM_WORDS.
- MEM_SIZE, 256, mem-map depth; ID_W = $clog2(MEM_SIZE).
- ALLOW_PARTIAL, 0, 1 = commit with any nonzero fresh mask; 0 = all words must be fresh.
- TIMEOUT_CYCLES, 0, HOLD cycles before a dropped commit; 0 disables.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- soft_clr  in  1  synchronous clear (driven from the RST_ID poll)
- wr_en  in  1  mem-map write strobe, one cycle per write
- wr_id  in  ID_W  mem-map index of the write
- wr_data  in  DATA_WIDTH  write data
- resp_valid  out  1  one-cycle pulse, response for an in-range write
- resp  out  2  OKAY=2'b00 / SLVERR=2'b10
- fresh  out  NUM_WORDS  per-word fresh mask (mem-map freshbit mirror)
- out_data  out  NUM_WORDS*DATA_WIDTH  committed register; word i at [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  committed value pending
- out_ready  in  1  consumer accepts
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Async reset: shadow=0, fresh=0, out_data=0, out_valid=0, resp_valid=0, resp=OKAY, timeout_err=0, hold counter=0, state=IDLE.
- States: IDLE (collecting) and HOLD (out_valid=1). All decisions use registered state. Responses come 1 cycle after wr_en.
- Word write, wr_id in [BASE_ID, BASE_ID+NUM_WORDS-1], any state:
  - shadow[wr_id-BASE_ID] <= wr_data; fresh bit set; resp OKAY.
  - Rewriting a fresh word overwrites it (last write wins).
- Valid write, wr_id = BASE_ID+NUM_WORDS:
  - Commit condition: fresh all-ones, or ALLOW_PARTIAL=1 and fresh != 0.
  - IDLE and commit condition met: out_data <= shadow (non-fresh words keep their previous shadow values); fresh <= 0; out_valid <= 1; go to HOLD; clear hold counter; resp OKAY. out_valid rises the cycle after the valid write.
  - IDLE and condition not met: no commit, fresh retained, resp SLVERR.
  - HOLD: busy; no commit, fresh retained, resp SLVERR. This applies even if the handshake completes in the same cycle.
- wr_id outside [BASE_ID, BASE_ID+NUM_WORDS]: ignored; no resp_valid.
- HOLD exit:
  - out_valid && out_ready: out_valid <= 0 next cycle; go to IDLE.
  - TIMEOUT_CYCLES>0: the counter increments each HOLD cycle without a handshake. At TIMEOUT_CYCLES-1: out_valid <= 0, timeout_err <= 1, go to IDLE.
  - A handshake in the same cycle as the timeout wins: accepted, no error.
- out_data holds its value after a handshake or timeout until the next commit.
- soft_clr, highest priority:
  - Next cycle: shadow=0, fresh=0, out_valid=0, timeout_err=0, IDLE. out_data is retained.
  - A coincident in-range write is dropped with resp SLVERR.
- Reset mid-HOLD: out_valid drops asynchronously.

Decomposition:
- mem_layout_pkg gains: resp_t typedef (2-bit, OKAY/EXOKAY/SLVERR/DECERR constants); bigreg_state_t enum {IDLE, HOLD}; per-register BASE_ID/NUM_WORDS constants reusing the existing ID macros.
- Sub-module hold_timer (counter, enable, clear, terminal-count pulse) is natural. It is reused by other RPOLL handshakes.

Test Plan:
- NUM_WORDS=2, BASE_ID=30: write id30=16'hBEEF, id31=16'h1234, id32=x -> out_data=32'h1234_BEEF, out_valid the cycle after the id32 write, three OKAY responses, fresh=2'b00 after commit.
- ALLOW_PARTIAL=0: write id30 only, then id32 -> resp SLVERR, fresh=2'b01, out_valid stays 0; then write id31 and id32 -> commit OK.
- ALLOW_PARTIAL=1, prior commit 32'h1234_BEEF: write id30=16'h0001, id32 -> out_data=32'h1234_0001.
- In HOLD with out_ready=0: write id30/id31 then id32 -> SLVERR, fresh=2'b11, out_data unchanged; assert out_ready, then rewrite id32 -> new commit.
- TIMEOUT_CYCLES=8, out_ready=0: out_valid high exactly 8 cycles, then timeout_err=1; soft_clr clears timeout_err. Repeat with out_ready raised on cycle 8 -> accepted, timeout_err=0.
- soft_clr coincident with a write to id31 -> SLVERR, fresh=0, shadow=0. Also: async rst mid-HOLD -> out_valid=0 immediately. Also: write to id29/id33 -> no resp_valid.
